// File: rtl/cache_fill_responder_if.sv
// Cache-side line-fill handshake plus backing-memory word-read port.
// The responder takes the slave view; the cache/memory side takes the master view.
interface cache_fill_responder_if #(
   parameter int ADDR_W = 25
);
   logic              sdram_req;
   logic [ADDR_W-1:0] req_addr;
   logic              sdram_fill;
   logic [15:0]       data_from_sdram;
   logic              busy;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [15:0]       mem_data;

   modport slave (
      input  sdram_req, req_addr, mem_ack, mem_data,
      output sdram_fill, data_from_sdram, busy, mem_req, mem_addr
   );

   modport master (
      output sdram_req, req_addr, mem_ack, mem_data,
      input  sdram_fill, data_from_sdram, busy, mem_req, mem_addr
   );
endinterface

// File: rtl/cache_fill_responder.sv
// Memory-side line-fill responder: fetches an 8-word line critical-word-first
// with wrap-around, buffers it, then streams it back behind a one-cycle fill strobe.
module cache_fill_responder #(
   parameter int ADDR_W    = 25,
   parameter int LINE_LOG2 = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   cache_fill_responder_if.slave  bus
);
   localparam int                 LINE_WORDS = 1 << LINE_LOG2;
   localparam int                 BASE_W     = ADDR_W - LINE_LOG2;
   localparam logic [LINE_LOG2:0] CNT_ONE    = (LINE_LOG2+1)'(1);
   localparam logic [LINE_LOG2:0] CNT_LAST   = (LINE_LOG2+1)'(LINE_WORDS - 1);
   localparam logic [LINE_LOG2:0] CNT_DONE   = (LINE_LOG2+1)'(LINE_WORDS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_armed;
   logic [LINE_LOG2:0]     r_cnt;
   logic [BASE_W-1:0]      r_base;
   logic [LINE_LOG2-1:0]   r_crit;
   logic [15:0]            r_buf [LINE_WORDS];

   logic                   r_fill;
   logic [15:0]            r_data;
   logic                   r_busy;
   logic                   r_mem_req;
   logic [ADDR_W-1:0]      r_mem_addr;

   logic [LINE_LOG2-1:0]   w_idx;
   logic [LINE_LOG2-1:0]   w_idx_next;
   logic                   w_store;

   // Word index wraps inside the line; the base bits never see a carry.
   assign w_idx      = r_crit + r_cnt[LINE_LOG2-1:0];
   assign w_idx_next = w_idx + LINE_LOG2'(1);
   assign w_store    = (r_state == FETCH) && bus.mem_ack;

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_buf[w_idx] <= bus.mem_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_armed    <= 1'b1;
         r_cnt      <= '0;
         r_base     <= '0;
         r_crit     <= '0;
         r_fill     <= 1'b0;
         r_data     <= '0;
         r_busy     <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         r_fill <= 1'b0;
         if (!bus.sdram_req) begin
            r_armed <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (bus.sdram_req && r_armed) begin
                  r_base     <= bus.req_addr[ADDR_W-1:LINE_LOG2];
                  r_crit     <= bus.req_addr[LINE_LOG2-1:0];
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= bus.req_addr;
                  r_state    <= FETCH;
               end
            end
            FETCH: begin
               if (bus.mem_ack) begin
                  if (r_cnt == CNT_LAST) begin
                     // Critical word was stored on the first ack, so it can go out now.
                     r_mem_req <= 1'b0;
                     r_fill    <= 1'b1;
                     r_data    <= r_buf[r_crit];
                     r_cnt     <= CNT_ONE;
                     r_state   <= STREAM;
                  end else begin
                     r_cnt      <= r_cnt + CNT_ONE;
                     r_mem_addr <= {r_base, w_idx_next};
                  end
               end
            end
            STREAM: begin
               if (r_cnt == CNT_DONE) begin
                  // A request still held here is stale; wait for it to drop first.
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  if (bus.sdram_req) begin
                     r_armed <= 1'b0;
                  end
               end else begin
                  r_data <= r_buf[w_idx];
                  r_cnt  <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.sdram_fill      = r_fill;
   assign bus.data_from_sdram = r_data;
   assign bus.busy            = r_busy;
   assign bus.mem_req         = r_mem_req;
   assign bus.mem_addr        = r_mem_addr;
endmodule
